// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the pipeline W stage
// (priority requester) and a long-latency execution unit whose results wait
// in a small FIFO. A starvation counter forces a one-cycle stall so queued
// results can drain. Queued results made stale by a younger pipeline write
// to the same register are killed and drop out without using the port.
//
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   WEN_W/WA_W/WD_W      W-stage write request (WEN_W active-low)
//   LL_VALID/LL_READY    long-latency result handshake
//   LL_WA/LL_WD          long-latency result address/data
//   RF_WEN/RF_WA/RF_WD   register-file write port (RF_WEN active-low)
//   STALL_REQ            hold M/W and upstream stages this cycle
//   LL_PENDING           FIFO holds at least one live entry
module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WEN_W,
  input  logic [AW-1:0] WA_W,
  input  logic [DW-1:0] WD_W,
  input  logic          LL_VALID,
  output logic          LL_READY,
  input  logic [AW-1:0] LL_WA,
  input  logic [DW-1:0] LL_WD,
  output logic          RF_WEN,
  output logic [AW-1:0] RF_WA,
  output logic [DW-1:0] RF_WD,
  output logic          STALL_REQ,
  output logic          LL_PENDING
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [AW-1:0]    wa_q [DEPTH];
  logic [DW-1:0]    wd_q [DEPTH];
  logic [DEPTH-1:0] kill_q, kill_d;
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [3:0]       starve_q, starve_d;
  logic             force_q, force_d;

  logic [DEPTH-1:0] occ;
  logic             head_valid, head_kill, head_live;
  logic             full, push, pop;
  logic             force_g, pipe_g, fifo_g, squash;

  always_comb begin
    occ = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      // slot i is occupied when its distance from the read pointer is below count
      occ[i] = CW'(PW'(i) - rd_ptr_q) < count_q;
    end

    head_valid = (count_q != '0);
    head_kill  = kill_q[rd_ptr_q];
    head_live  = head_valid & ~head_kill;

    full     = (count_q == CW'(DEPTH));
    LL_READY = ~RST & ~full;
    push     = LL_VALID & LL_READY;

    force_g = force_q & head_live;
    pipe_g  = ~force_g & ~WEN_W;
    fifo_g  = head_live & ~pipe_g;
    // a killed head leaves without the port, so it may pop alongside a pipeline grant
    pop     = fifo_g | (head_valid & head_kill);
    squash  = pipe_g & (WA_W != '0);

    count_d = count_q + CW'(push) - CW'(pop);

    starve_d = '0;
    if (head_live && !fifo_g) begin
      starve_d = (starve_q == SMAX) ? starve_q : starve_q + 4'd1;
    end
    force_d = (starve_d == SMAX);

    kill_d = kill_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (squash && occ[i] && (wa_q[i] == WA_W)) kill_d[i] = 1'b1;
    end
    if (push) kill_d[wr_ptr_q] = squash & (LL_WA == WA_W);

    LL_PENDING = ~RST & |(occ & ~kill_q);
  end

  always_comb begin
    RF_WEN    = 1'b1;
    RF_WA     = '0;
    RF_WD     = '0;
    STALL_REQ = 1'b0;
    if (!RST) begin
      if (fifo_g) begin
        RF_WEN    = 1'b0;
        RF_WA     = wa_q[rd_ptr_q];
        RF_WD     = wd_q[rd_ptr_q];
        STALL_REQ = force_g;
      end else if (pipe_g) begin
        RF_WEN = 1'b0;
        RF_WA  = WA_W;
        RF_WD  = WD_W;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      kill_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      force_q  <= 1'b0;
    end else begin
      kill_q   <= kill_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      force_q  <= force_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      wa_q[wr_ptr_q] <= LL_WA;
      wd_q[wr_ptr_q] <= LL_WD;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        WEN_W;
  logic [4:0]  WA_W;
  logic [31:0] WD_W;
  logic        LL_VALID;
  logic        LL_READY;
  logic [4:0]  LL_WA;
  logic [31:0] LL_WD;
  logic        RF_WEN;
  logic [4:0]  RF_WA;
  logic [31:0] RF_WD;
  logic        STALL_REQ;
  logic        LL_PENDING;

  int checks   = 0;
  int failures = 0;

  logic        rf_clr;
  logic [31:0] rf [32];

  wb_port_arbiter #(
    .DEPTH(2),
    .DW(32),
    .AW(5),
    .STARVE_MAX(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .WEN_W(WEN_W),
    .WA_W(WA_W),
    .WD_W(WD_W),
    .LL_VALID(LL_VALID),
    .LL_READY(LL_READY),
    .LL_WA(LL_WA),
    .LL_WD(LL_WD),
    .RF_WEN(RF_WEN),
    .RF_WA(RF_WA),
    .RF_WD(RF_WD),
    .STALL_REQ(STALL_REQ),
    .LL_PENDING(LL_PENDING)
  );

  always #5 CLK = ~CLK;

  // register-file model fed by the write port
  always @(posedge CLK) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (!RF_WEN) begin
      rf[RF_WA] <= RF_WD;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                       input logic llv, input logic [4:0] llwa, input logic [31:0] llwd);
    WEN_W = wen; WA_W = wa; WD_W = wd;
    LL_VALID = llv; LL_WA = llwa; LL_WD = llwd;
    #1;
  endtask

  task automatic chk_port(input string tag, input logic wen, input logic [4:0] wa,
                          input logic [31:0] wd, input logic stall);
    chk({tag, "_wen"}, 32'(RF_WEN), 32'(wen));
    if (!wen) begin
      chk({tag, "_wa"}, 32'(RF_WA), 32'(wa));
      chk({tag, "_wd"}, RF_WD, wd);
    end
    chk({tag, "_stall"}, 32'(STALL_REQ), 32'(stall));
  endtask

  initial begin
    RST = 1'b1;
    rf_clr = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    // reset state
    chk("rst_ready", 32'(LL_READY), 32'd0);
    chk("rst_pend", 32'(LL_PENDING), 32'd0);
    chk("rst_wa", 32'(RF_WA), 32'd0);
    chk("rst_wd", RF_WD, 32'd0);
    chk_port("rst", 1, 0, 0, 0);
    RST = 1'b0;
    rf_clr = 1'b0;

    // single LL result drains when the pipeline is idle
    drive(1, 0, 0, 1, 5'd3, 32'h11);
    chk("t1_ready", 32'(LL_READY), 32'd1);
    chk_port("t1_c0", 1, 0, 0, 0);
    cyc();
    drive(1, 0, 0, 0, 0, 0);
    chk_port("t1_c1", 0, 5'd3, 32'h11, 0);
    chk("t1_pend1", 32'(LL_PENDING), 32'd1);
    cyc();
    chk("t1_pend2", 32'(LL_PENDING), 32'd0);
    chk_port("t1_c2", 1, 0, 0, 0);
    chk("t1_rf3", rf[3], 32'h11);

    // starvation forces a one-cycle stall
    drive(0, 5'd5, 32'h50, 1, 5'd7, 32'hAB);
    chk_port("t2_c0", 0, 5'd5, 32'h50, 0);
    cyc();
    for (int k = 1; k <= 4; k++) begin
      drive(0, 5'd5, 32'h50, 0, 0, 0);
      chk_port($sformatf("t2_c%0d", k), 0, 5'd5, 32'h50, 0);
      chk($sformatf("t2_pend%0d", k), 32'(LL_PENDING), 32'd1);
      cyc();
    end
    chk_port("t2_force", 0, 5'd7, 32'hAB, 1);
    cyc();
    chk_port("t2_resume", 0, 5'd5, 32'h50, 0);
    chk("t2_pend_end", 32'(LL_PENDING), 32'd0);
    drive(1, 0, 0, 0, 0, 0);
    cyc();
    chk("t2_rf7", rf[7], 32'hAB);

    // fill the FIFO while the pipeline writes continuously
    drive(0, 5'd1, 32'h01, 1, 5'd10, 32'hA0);
    chk("t3_rdy0", 32'(LL_READY), 32'd1);
    cyc();
    drive(0, 5'd1, 32'h01, 1, 5'd11, 32'hB0);
    chk("t3_rdy1", 32'(LL_READY), 32'd1);
    cyc();
    drive(0, 5'd1, 32'h01, 1, 5'd9, 32'h90);
    chk("t3_rdy2", 32'(LL_READY), 32'd0);
    cyc();
    chk("t3_rdy3", 32'(LL_READY), 32'd0);
    cyc();
    chk("t3_rdy4", 32'(LL_READY), 32'd0);
    chk_port("t3_c4", 0, 5'd1, 32'h01, 0);
    cyc();
    chk_port("t3_force", 0, 5'd10, 32'hA0, 1);
    chk("t3_rdy5", 32'(LL_READY), 32'd0);
    cyc();
    chk("t3_rdy6", 32'(LL_READY), 32'd1);
    chk_port("t3_c6", 0, 5'd1, 32'h01, 0);
    cyc();
    drive(1, 0, 0, 0, 0, 0);
    chk_port("t3_drain11", 0, 5'd11, 32'hB0, 0);
    cyc();
    chk_port("t3_drain9", 0, 5'd9, 32'h90, 0);
    chk("t3_rdy8", 32'(LL_READY), 32'd1);
    cyc();
    chk_port("t3_empty", 1, 0, 0, 0);
    chk("t3_pend", 32'(LL_PENDING), 32'd0);

    // WAW squash of a queued entry
    drive(0, 5'd1, 32'h01, 1, 5'd4, 32'h44);
    cyc();
    drive(0, 5'd4, 32'h55, 0, 0, 0);
    chk_port("t4_pipe", 0, 5'd4, 32'h55, 0);
    chk("t4_pend_pre", 32'(LL_PENDING), 32'd1);
    cyc();
    drive(1, 0, 0, 0, 0, 0);
    chk_port("t4_silent", 1, 0, 0, 0);
    chk("t4_pend_post", 32'(LL_PENDING), 32'd0);
    cyc();
    chk_port("t4_after", 1, 0, 0, 0);
    chk("t4_rf4", rf[4], 32'h55);

    // address 0 never kills
    drive(0, 5'd1, 32'h01, 1, 5'd0, 32'h77);
    cyc();
    drive(0, 5'd0, 32'h33, 0, 0, 0);
    chk("t5_pend", 32'(LL_PENDING), 32'd1);
    cyc();
    drive(1, 0, 0, 0, 0, 0);
    chk_port("t5_drain", 0, 5'd0, 32'h77, 0);
    cyc();
    chk("t5_pend_end", 32'(LL_PENDING), 32'd0);

    // entry pushed alongside a same-address pipeline write enters killed
    drive(0, 5'd6, 32'h66, 1, 5'd6, 32'h99);
    cyc();
    drive(1, 0, 0, 0, 0, 0);
    chk_port("t6_c1", 1, 0, 0, 0);
    chk("t6_pend1", 32'(LL_PENDING), 32'd0);
    cyc();
    chk_port("t6_c2", 1, 0, 0, 0);
    chk("t6_pend2", 32'(LL_PENDING), 32'd0);
    chk("t6_rf6", rf[6], 32'h66);

    // reset with two queued entries and the counter at 3
    drive(0, 5'd1, 32'h01, 1, 5'd12, 32'hC0);
    cyc();
    drive(0, 5'd1, 32'h01, 1, 5'd13, 32'hD0);
    cyc();
    drive(0, 5'd1, 32'h01, 0, 0, 0);
    cyc();
    cyc();
    RST = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    chk_port("t7_rst", 1, 0, 0, 0);
    chk("t7_rst_wa", 32'(RF_WA), 32'd0);
    chk("t7_rst_wd", RF_WD, 32'd0);
    chk("t7_rst_pend", 32'(LL_PENDING), 32'd0);
    chk("t7_rst_ready", 32'(LL_READY), 32'd0);
    cyc();
    RST = 1'b0;
    #1;
    chk_port("t7_post0", 1, 0, 0, 0);
    chk("t7_post_pend", 32'(LL_PENDING), 32'd0);
    chk("t7_post_ready", 32'(LL_READY), 32'd1);
    cyc();
    chk_port("t7_post1", 1, 0, 0, 0);
    cyc();
    chk_port("t7_post2", 1, 0, 0, 0);
    chk("t7_rf12", rf[12], 32'h0);
    chk("t7_rf13", rf[13], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
